vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Free-running VGA raster generator for 1024x768@60 Hz; pixel clock 65 MHz.
- Head of the display pipeline: produces the VGA bus that the rectangle, card and background draw stages consume, and those stages consume it strictly after this block.
- Also provides a one-cycle frame tick and a wrapping frame counter, which game logic uses for animation and blink timing.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- vga_out  out  `VGA_BUS_SIZE  packed VGA bus (rgb, hcount, vcount, hs, vs, hblnk, vblnk) via the shared VGA bus macros
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking
- frame_cnt  out  8  frame counter, increments on each frame_tick

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806)
- Reset: asserting rst (rst=0) clears outputs immediately, without waiting for a clock edge. Reset values:
  - hcount_out=0, vcount_out=0, rgb_out=0, hblnk_out=0, vblnk_out=0
  - hs_out=vs_out=~SYNC_POL (inactive level)
  - frame_tick=0, frame_cnt=0
- Release: the first rising pclk edge after rst goes high presents hcount=1, vcount=0.
- Counters (11-bit):
  - hcount increments every pclk edge.
  - When hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - When vcount==V_TOTAL-1 at that same edge, vcount also wraps to 0.
  - hcount and vcount never exceed H_TOTAL-1 and V_TOTAL-1.
- Decode: all outputs are registered and decoded from the next-state counts, so in every cycle they are consistent with the hcount_out/vcount_out presented in that cycle. Zero combinational output paths.
  - hblnk=1 iff hcount>=H_ACTIVE (1024..1343)
  - vblnk=1 iff vcount>=V_ACTIVE (768..805)
  - hs active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183)
  - vs active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (771..776)
  - vs is evaluated per line, independent of hcount.
  - Active level of hs/vs = SYNC_POL.
- rgb_out is constant 0: this block drives black and later stages overwrite it.
- frame_tick:
  - High for exactly one cycle, in the cycle where the output shows hcount==0 && vcount==V_ACTIVE.
  - Never high after reset until that point is reached.
- frame_cnt:
  - Updates on the same edge that raises frame_tick, so the new value is visible together with frame_tick.
  - 8-bit, wraps 255 -> 0.
- Latency: none relative to its own counters. Downstream stages see the bus one register stage after the count update.
- Reset mid-frame: all state returns to reset values immediately. The raster restarts from (0,0) on release, with no partial-frame frame_tick.
- Legal parameter range: total counts must be <= 2047; each porch and sync value must be >= 1.

Test Plan:
- Reset then release: hold rst=0 for 5 cycles, mid-run assert async (between edges) -> outputs return to 0/inactive immediately; first edge after release shows hcount=1, vcount=0, hs=vs=1.
- Line wrap: run to hcount=1343 -> next cycle hcount=0, vcount+1; hblnk=1 exactly for hcount 1024..1343; hs=0 exactly for hcount 1048..1183 (136 cycles).
- Frame wrap: run to (1343,805) -> next cycle (0,0) with vblnk=0; vblnk=1 exactly for vcount 768..805; vs=0 exactly for lines 771..776.
- Frame tick: over 3 full frames (3*1344*806 cycles) -> frame_tick pulses exactly 3 times, each width 1, at (0,768); frame_cnt reads 1,2,3 at the pulses.
- Counter wrap: preload/run 256 frames (or force via reduced parameters H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1) -> frame_cnt goes 255 -> 0, and period is 14*7=98 cycles.
- Polarity: SYNC_POL=1 -> hs/vs reset to 0 and are high only within the sync windows above; blanking is unchanged.

Source files
------------

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing - free-running 1024x768@60 Hz raster generator (65 MHz pixel clock)
//
// Head of the display pipeline. Produces the packed VGA bus consumed by the
// later draw stages, plus a one-cycle frame tick at the start of vertical
// blanking and a wrapping 8-bit frame counter for animation/blink timing.
//
// Ports:
//   pclk        in   pixel clock, all logic on the rising edge
//   rst         in   asynchronous reset, active-low (0 = reset)
//   vga_out     out  packed VGA bus {hcount, vcount, hs, vs, hblnk, vblnk, rgb}
//   frame_tick  out  one-cycle pulse when the output shows (0, V_ACTIVE)
//   frame_cnt   out  frame counter, advances together with frame_tick
// -----------------------------------------------------------------------------

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE   38
`define VGA_HCOUNT     37:27
`define VGA_VCOUNT     26:16
`define VGA_HS         15
`define VGA_VS         14
`define VGA_HBLNK      13
`define VGA_VBLNK      12
`define VGA_RGB        11:0
`endif

module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int SYNC_POL = 0
) (
    input  logic                     pclk,
    input  logic                     rst,
    output logic [`VGA_BUS_SIZE-1:0] vga_out,
    output logic                     frame_tick,
    output logic [7:0]               frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT       = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT       = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON     = 1'(SYNC_POL);

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [10:0] hcount_nxt;
    logic [10:0] vcount_nxt;
    logic        hs;
    logic        vs;
    logic        hblnk;
    logic        vblnk;

    always_comb begin
        hcount_nxt = hcount + 11'd1;
        vcount_nxt = vcount;
        if (hcount == H_LAST) begin
            hcount_nxt = '0;
            vcount_nxt = (vcount == V_LAST) ? '0 : vcount + 11'd1;
        end
    end

    // Every decoded output is registered from the next-state counts so that it
    // lines up with the count registered on the same edge.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount     <= '0;
            vcount     <= '0;
            hblnk      <= 1'b0;
            vblnk      <= 1'b0;
            hs         <= ~SYNC_ON;
            vs         <= ~SYNC_ON;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            hcount <= hcount_nxt;
            vcount <= vcount_nxt;
            hblnk  <= (hcount_nxt >= H_ACT);
            vblnk  <= (vcount_nxt >= V_ACT);
            hs     <= (hcount_nxt >= H_SYNC_BEG && hcount_nxt < H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
            vs     <= (vcount_nxt >= V_SYNC_BEG && vcount_nxt < V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
            if (hcount_nxt == '0 && vcount_nxt == V_ACT) begin
                frame_tick <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
            end else begin
                frame_tick <= 1'b0;
            end
        end
    end

    // This stage always drives black; later stages overwrite rgb.
    assign vga_out = {hcount, vcount, hs, vs, hblnk, vblnk, 12'h000};

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing - bench for vga_timing
//
// Three instances share clock and reset: full-size timing (line wrap, sync and
// blanking on real numbers), a reduced raster (frame wrap, frame tick, 8-bit
// counter wrap) and the reduced raster with active-high sync. Expected outputs
// come from the cycle count since reset release using plain div/mod arithmetic.
// -----------------------------------------------------------------------------

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE   38
`define VGA_HCOUNT     37:27
`define VGA_VCOUNT     26:16
`define VGA_HS         15
`define VGA_VS         14
`define VGA_HBLNK      13
`define VGA_VBLNK      12
`define VGA_RGB        11:0
`endif

module tb_vga_timing;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    logic [`VGA_BUS_SIZE-1:0] bus_f, bus_s, bus_p;
    logic                     tick_f, tick_s, tick_p;
    logic [7:0]               cnt_f, cnt_s, cnt_p;

    int n      = 0;
    int checks = 0;
    int fails  = 0;

    always #5 pclk = ~pclk;

    vga_timing dut_full (
        .pclk       (pclk),
        .rst        (rst),
        .vga_out    (bus_f),
        .frame_tick (tick_f),
        .frame_cnt  (cnt_f)
    );

    vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (0)
    ) dut_small (
        .pclk       (pclk),
        .rst        (rst),
        .vga_out    (bus_s),
        .frame_tick (tick_s),
        .frame_cnt  (cnt_s)
    );

    vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1)
    ) dut_pol (
        .pclk       (pclk),
        .rst        (rst),
        .vga_out    (bus_p),
        .frame_tick (tick_p),
        .frame_cnt  (cnt_p)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d since release)", tag, obs, exp, n);
        end
    endtask

    // Reference: the raster position is simply the cycle count folded by the
    // line and frame lengths; frame ticks occur every frame starting at line
    // V_ACTIVE of the first frame.
    task automatic check_inst(input string tag,
                              input int ha, input int hfp, input int hsw, input int hbp,
                              input int va, input int vfp, input int vsw, input int vbp,
                              input bit pol,
                              input logic [`VGA_BUS_SIZE-1:0] bus,
                              input logic tick, input logic [7:0] cnt);
        int ht, vt, h, v, first, frame;
        logic hs_e, vs_e, hb_e, vb_e, tick_e;
        logic [7:0] cnt_e;
        logic [`VGA_BUS_SIZE-1:0] bus_e;
        ht    = ha + hfp + hsw + hbp;
        vt    = va + vfp + vsw + vbp;
        frame = ht * vt;
        h     = n % ht;
        v     = (n / ht) % vt;
        hb_e  = (h >= ha);
        vb_e  = (v >= va);
        hs_e  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
        vs_e  = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
        first = va * ht;
        tick_e = (n > 0) && (h == 0) && (v == va);
        cnt_e  = (n >= first) ? 8'(((n - first) / frame + 1) % 256) : 8'd0;
        bus_e  = {11'(h), 11'(v), hs_e, vs_e, hb_e, vb_e, 12'h000};
        chk({tag, ".bus"},  64'(bus),  64'(bus_e));
        chk({tag, ".tick"}, 64'(tick), 64'(tick_e));
        chk({tag, ".cnt"},  64'(cnt),  64'(cnt_e));
    endtask

    task automatic check_all();
        check_inst("full",  1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, bus_f, tick_f, cnt_f);
        check_inst("small", 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, bus_s, tick_s, cnt_s);
        check_inst("pol",   8, 2, 2, 2, 4, 1, 1, 1, 1'b1, bus_p, tick_p, cnt_p);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge pclk);
            if (rst) n++;
            @(negedge pclk);
            check_all();
        end
    endtask

    // Assert reset between clock edges, check it takes effect before the next
    // edge, hold it a few cycles, then release on a falling edge.
    task automatic async_reset(input int hold);
        @(posedge pclk);
        #($urandom_range(1, 3));
        rst = 1'b0;
        n   = 0;
        #1;
        check_all();
        run(hold);
        rst = 1'b1;
    endtask

    initial begin
        #1;
        rst = 1'b0;
        n   = 0;
        #1;
        check_all();
        run(5);
        rst = 1'b1;

        // Two full-size line wraps plus ~30 reduced frames.
        run(2 * 1344 + 300 + int'($urandom_range(0, 200)));

        async_reset(int'($urandom_range(1, 5)));

        // 256+ reduced frames: frame_cnt wraps 255 -> 0.
        run(256 * 98 + 200 + int'($urandom_range(0, 150)));

        async_reset(int'($urandom_range(1, 5)));
        run(400 + int'($urandom_range(0, 100)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
